// File: rtl/hazard_match_gen.sv
// Register-match generator for a dual-issue forwarding unit: tracks decode
// sources into E and both pipes' destinations through E/M/W, flags source/destination hits.
module hazard_match_gen #(
    parameter int REG_W  = 4,
    parameter int PC_IDX = 15,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] RA1D,
    input  logic [REG_W-1:0] RA2D,
    input  logic             UseRA1D,
    input  logic             UseRA2D,
    input  logic [REG_W-1:0] WA3D,
    input  logic             RegWriteAD,
    input  logic [REG_W-1:0] WA4D,
    input  logic             RegWriteBD,
    input  logic             FlushE,
    input  logic             StallD,
    output logic [7:0]       Match,
    output logic [CNT_W-1:0] StallCount
);

    typedef struct packed {
        logic [REG_W-1:0] wa3;
        logic [REG_W-1:0] wa4;
        logic             wr_a;
        logic             wr_b;
    } dest_t;

    localparam logic [REG_W-1:0] PC_REG  = REG_W'(PC_IDX);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [REG_W-1:0] ra1_e, ra2_e;
    logic             use1_e, use2_e;
    dest_t            dest_e, dest_m, dest_w;

    // NOTE: non-blocking assignments so every stage samples its predecessor's pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            ra1_e  <= '0;
            ra2_e  <= '0;
            use1_e <= 1'b0;
            use2_e <= 1'b0;
            dest_e <= '0;
            dest_m <= '0;
            dest_w <= '0;
        end else begin
            // A flush only clears the qualifiers; the stale indices are harmless without them.
            ra1_e       <= RA1D;
            ra2_e       <= RA2D;
            use1_e      <= UseRA1D && !FlushE;
            use2_e      <= UseRA2D && !FlushE;
            dest_e.wa3  <= WA3D;
            dest_e.wa4  <= WA4D;
            dest_e.wr_a <= RegWriteAD && !FlushE;
            dest_e.wr_b <= RegWriteBD && !FlushE;
            dest_m      <= dest_e;
            dest_w      <= dest_m;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            StallCount <= '0;
        end else if (StallD && (StallCount != CNT_MAX)) begin
            StallCount <= StallCount + 1'b1;
        end
    end

    function automatic logic hit(input logic             use_src,
                                 input logic [REG_W-1:0] ra,
                                 input logic             wr,
                                 input logic [REG_W-1:0] wa);
        return use_src && wr && (ra == wa) && (ra != PC_REG);
    endfunction

    assign Match = {
        hit(use1_e, ra1_e, dest_m.wr_a, dest_m.wa3),
        hit(use1_e, ra1_e, dest_w.wr_a, dest_w.wa3),
        hit(use1_e, ra1_e, dest_m.wr_b, dest_m.wa4),
        hit(use1_e, ra1_e, dest_w.wr_b, dest_w.wa4),
        hit(use2_e, ra2_e, dest_m.wr_a, dest_m.wa3),
        hit(use2_e, ra2_e, dest_w.wr_a, dest_w.wa3),
        hit(use2_e, ra2_e, dest_m.wr_b, dest_m.wa4),
        hit(use2_e, ra2_e, dest_w.wr_b, dest_w.wa4)
    };

endmodule

// File: doc/hazard_match_gen.md
HAZARD_MATCH_GEN -- requirements
Module: hazard_match_gen

Interface
REQ-001 The block SHALL have parameter REG_W, default 4, giving the register index width.
REQ-002 The block SHALL have parameter PC_IDX, default 15, giving the PC register index, which is never forwarded.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the stall counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port RA1D, input, REG_W bits: source register 1 of the decode-stage instruction.
REQ-007 The block SHALL have port RA2D, input, REG_W bits: source register 2 of the decode-stage instruction.
REQ-008 The block SHALL have port UseRA1D, input, 1 bit: the decode instruction reads RA1D.
REQ-009 The block SHALL have port UseRA2D, input, 1 bit: the decode instruction reads RA2D.
REQ-010 The block SHALL have port WA3D, input, REG_W bits: pipe-A destination register in decode.
REQ-011 The block SHALL have port RegWriteAD, input, 1 bit: pipe A writes WA3D.
REQ-012 The block SHALL have port WA4D, input, REG_W bits: pipe-B destination register in decode.
REQ-013 The block SHALL have port RegWriteBD, input, 1 bit: pipe B writes WA4D.
REQ-014 The block SHALL have port FlushE, input, 1 bit: turns the E stage into a bubble on the next edge.
REQ-015 The block SHALL have port StallD, input, 1 bit: the decode stage is stalled this cycle; used for statistics only.
REQ-016 The block SHALL have port Match, output, 8 bits: {1E_M_3, 1E_W_3, 1E_M_4, 1E_W_4, 2E_M_3, 2E_W_3, 2E_M_4, 2E_W_4}, MSB first.
REQ-017 The block SHALL have port StallCount, output, CNT_W bits: a saturating count of stalled cycles.

Function
REQ-018 The block SHALL hold E-stage registers RA1E, RA2E, Use1E, Use2E, WA3E, WA4E, WrAE and WrBE, loaded from the decode inputs on every edge.
REQ-019 On an edge with FlushE=1, the block SHALL load Use1E, Use2E, WrAE and WrBE with 0 (bubble); the index registers may take any value.
REQ-020 On every edge, the block SHALL advance WA3, WA4, WrA and WrB from E to M and from M to W; M and W never stall or flush.
REQ-021 Latency: a decode-stage instruction SHALL reach E after 1 edge, M after 2 edges and W after 3 edges.
REQ-022 Match bit 1E_X_k SHALL equal Use1E AND WrkX AND (RA1E==WAkX) AND (RA1E!=PC_IDX), for X in {M,W} and k=3 (pipe A) or k=4 (pipe B); 2E_X_k uses Use2E and RA2E in the same way.
REQ-023 Match SHALL be combinational from registered state only; no decode input SHALL reach Match within the same cycle.
REQ-024 When both pipes write the same register in the same stage, the block SHALL assert both Match bits; priority belongs to the consumer.
REQ-025 When a source matches in both M and W, the block SHALL assert both the M bit and the W bit.
REQ-026 StallCount SHALL increment by 1 on each edge with StallD=1 and SHALL hold at all-ones once saturated, with no wrap-around.
REQ-027 The block SHALL NOT depend on StallD for any pipeline register; the consumer asserts FlushE on stalls.

Reset
REQ-028 On an edge with reset=1, the block SHALL clear all E, M and W registers and StallCount to 0, so that Match=8'h00 from the next cycle.
REQ-029 Reset SHALL take priority over FlushE and StallD in the same cycle.
REQ-030 Reset mid-operation SHALL discard all in-flight entries; no stale Match bit SHALL be asserted after the reset edge.
REQ-031 The first instruction after reset is released SHALL see no matches against pre-reset state.

Verification
REQ-032 The bench SHALL cover: pipe A writes r2 (WA3D=2, RegWriteAD=1), then the next instruction reads RA1D=2 -> with the reader in E, Match=8'b1000_0000; one edge later, with an unrelated instruction in E, Match=8'h00.
REQ-033 The bench SHALL cover: pipe B writes r5, then a filler instruction, then a read of RA2D=5 -> Match=8'b0000_0001 while the reader is in E.
REQ-034 The bench SHALL cover: pipe A writes r3, then pipe B writes r3 in the next instruction, then a read of RA1D=RA2D=3 -> Match=8'b0110_0110.
REQ-035 The bench SHALL cover: writer with WA3D=15, then a read of RA1D=15 -> Match=8'h00; separately, a read of r2 with UseRA1D=0 -> Match=8'h00.
REQ-036 The bench SHALL cover: writer of r4 followed by FlushE=1 while it is in D -> the bubble produces no matches; reader of r4 with FlushE=1 -> its E slot shows Match=8'h00.
REQ-037 The bench SHALL cover: StallD held for 70000 cycles -> StallCount=16'hFFFF; reset asserted with FlushE=1 -> StallCount=0 and Match=8'h00 on the next cycle.
